// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants for the RV32I memory stage.
//   - mem_op encodings (NONE/LOAD/STORE; 3 is reserved and behaves as NONE)
//   - RV32I load/store funct3 codes
//   - FSM state and access-size enums
//   - acc_size(): access width for a load or store funct3
//     (invalid funct3 decodes as a word access)
package lsu_pkg;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} lsu_state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_e;

  function automatic acc_size_e acc_size(input logic is_load, input logic [2:0] f3);
    acc_size_e sz;
    sz = SZ_WORD;
    if (is_load) begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the memory stage.
//   Request side (from EX): i_mem_op, i_funct3, i_addr_lo, i_st_data
//     -> o_misalign, o_st_be, o_st_wdata
//   Response side (captured request): i_ld_funct3, i_ld_addr_lo, i_ld_rdata
//     -> o_ld_data (selected lane, sign/zero extended)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_mem_op,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_st_data,
  output logic        o_misalign,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  acc_size_e   w_size;
  logic        w_is_mem;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_size     = acc_size(i_mem_op == MEM_LOAD, i_funct3);
    w_is_mem   = (i_mem_op == MEM_LOAD) || (i_mem_op == MEM_STORE);
    o_misalign = w_is_mem &&
                 (((w_size == SZ_HALF) && i_addr_lo[0]) ||
                  ((w_size == SZ_WORD) && (i_addr_lo != 2'b00)));
    case (w_size)
      SZ_BYTE: begin
        o_st_be    = 4'b0001 << i_addr_lo;
        o_st_wdata = {4{i_st_data[7:0]}};
      end
      SZ_HALF: begin
        o_st_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_st_wdata = {2{i_st_data[15:0]}};
      end
      default: begin
        o_st_be    = '1;
        o_st_wdata = i_st_data;
      end
    endcase
  end

  always_comb begin
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_ld_rdata[7:0];
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      default: w_byte = i_ld_rdata[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    case (i_ld_funct3)
      F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_ld_data = {24'h0, w_byte};
      F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_ld_data = {16'h0, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: RV32I memory stage. Passes ALU results through to MEM/WB, or runs a
// single req/gnt/rvalid data-memory transaction for loads and stores.
//   EX side : ex_valid, ex_result, ex_store_data, ex_mem_op, ex_funct3, ex_rd,
//             ex_reg_we in; lsu_stall out (high whenever not IDLE)
//   Bus     : dmem_req/we/addr/wdata/be out; dmem_gnt/rvalid/rdata in
//   WB      : wb_valid/we/rd/data registered outputs; misalign one-cycle pulse
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [1:0]        ex_mem_op,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_we,
  output logic              lsu_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign
);

  lsu_state_e r_state, w_state_nxt;

  logic [ADDR_W-3:0] r_addr_hi;
  logic [1:0]        r_addr_lo;
  logic              r_we;
  logic [3:0]        r_be;
  logic [XLEN-1:0]   r_wdata;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;
  logic              r_reg_we;

  logic              r_wb_valid, r_wb_we, r_misalign;
  logic [4:0]        r_wb_rd;
  logic [XLEN-1:0]   r_wb_data;

  logic              w_wb_valid, w_wb_we, w_misalign_nxt, w_capture;
  logic [4:0]        w_wb_rd;
  logic [XLEN-1:0]   w_wb_data;
  logic              w_is_load, w_is_store;
  logic              w_misalign;
  logic [3:0]        w_st_be;
  logic [XLEN-1:0]   w_st_wdata, w_ld_data;

  assign w_is_load  = (ex_mem_op == MEM_LOAD);
  assign w_is_store = (ex_mem_op == MEM_STORE);

  lsu_align u_align (
    .i_mem_op     (ex_mem_op),
    .i_funct3     (ex_funct3),
    .i_addr_lo    (ex_result[1:0]),
    .i_st_data    (ex_store_data),
    .o_misalign   (w_misalign),
    .o_st_be      (w_st_be),
    .o_st_wdata   (w_st_wdata),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_ld_rdata   (dmem_rdata),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_capture      = 1'b0;
    w_wb_valid     = 1'b0;
    w_wb_we        = 1'b0;
    w_misalign_nxt = 1'b0;
    w_wb_rd        = r_wb_rd;
    w_wb_data      = r_wb_data;
    case (r_state)
      ST_IDLE: begin
        if (ex_valid) begin
          if ((w_is_load || w_is_store) && w_misalign) begin
            w_misalign_nxt = 1'b1;
            w_wb_valid     = 1'b1;
            w_wb_rd        = ex_rd;
          end else if (w_is_load || w_is_store) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            w_wb_valid = 1'b1;
            w_wb_we    = ex_reg_we;
            w_wb_rd    = ex_rd;
            w_wb_data  = ex_result;
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          if (r_we) begin
            w_wb_valid  = 1'b1;
            w_wb_rd     = r_rd;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (dmem_rvalid) begin
          w_wb_valid  = 1'b1;
          w_wb_we     = r_reg_we;
          w_wb_rd     = r_rd;
          w_wb_data   = w_ld_data;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr_hi  <= '0;
      r_addr_lo  <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_funct3   <= '0;
      r_rd       <= '0;
      r_reg_we   <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_wb_valid <= w_wb_valid;
      r_wb_we    <= w_wb_we;
      r_wb_rd    <= w_wb_rd;
      r_wb_data  <= w_wb_data;
      r_misalign <= w_misalign_nxt;
      if (w_capture) begin
        r_addr_hi <= ex_result[ADDR_W-1:2];
        r_addr_lo <= ex_result[1:0];
        r_we      <= w_is_store;
        r_be      <= w_is_store ? w_st_be : 4'b1111;
        r_wdata   <= w_is_store ? w_st_wdata : '0;
        r_funct3  <= ex_funct3;
        r_rd      <= ex_rd;
        r_reg_we  <= ex_reg_we;
      end
    end
  end

  assign lsu_stall  = (r_state != ST_IDLE);
  assign dmem_req   = (r_state == ST_REQ);
  assign dmem_we    = r_we;
  assign dmem_addr  = {r_addr_hi, 2'b00};
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;
  assign wb_valid   = r_wb_valid;
  assign wb_we      = r_wb_we;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign misalign   = r_misalign;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk, rst;
  logic        ex_valid;
  logic [31:0] ex_result, ex_store_data;
  logic [1:0]  ex_mem_op;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  logic        lsu_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  mem_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
    .ex_mem_op(ex_mem_op), .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
    .lsu_stall(lsu_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rwe;
    logic        e_mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_wbwe;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[16];

  task automatic present(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd, input logic we);
    ex_valid = 1'b1; ex_mem_op = op; ex_funct3 = f3; ex_result = a;
    ex_store_data = sd; ex_rd = rd; ex_reg_we = we;
  endtask

  // Applies one vector with gnt in the first REQ cycle and rvalid in the first RESP cycle.
  task automatic run_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({p, "_idle_stall"}, {31'b0, lsu_stall}, 32'd0);
    present(v.op, v.f3, v.addr, v.sdata, v.rd, v.rwe);
    @(negedge clk);
    ex_valid = 1'b0;
    if (v.op == 2'd1 || v.op == 2'd2) begin
      if (v.e_mis) begin
        chk({p, "_mis"},    {31'b0, misalign}, 32'd1);
        chk({p, "_wbv"},    {31'b0, wb_valid}, 32'd1);
        chk({p, "_wbwe"},   {31'b0, wb_we},    32'd0);
        chk({p, "_noreq"},  {31'b0, dmem_req}, 32'd0);
        chk({p, "_stall"},  {31'b0, lsu_stall}, 32'd0);
      end else begin
        chk({p, "_req"},    {31'b0, dmem_req}, 32'd1);
        chk({p, "_we"},     {31'b0, dmem_we},  {31'b0, v.op == 2'd2});
        chk({p, "_addr"},   dmem_addr,         v.e_addr);
        chk({p, "_be"},     {28'b0, dmem_be},  {28'b0, v.e_be});
        if (v.op == 2'd2) chk({p, "_wdata"}, dmem_wdata, v.e_wdata);
        chk({p, "_stall"},  {31'b0, lsu_stall}, 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        chk({p, "_reqdrop"}, {31'b0, dmem_req}, 32'd0);
        if (v.op == 2'd2) begin
          chk({p, "_wbv"},  {31'b0, wb_valid}, 32'd1);
          chk({p, "_wbwe"}, {31'b0, wb_we},    32'd0);
        end else begin
          chk({p, "_resp_wbv"}, {31'b0, wb_valid}, 32'd0);
          chk({p, "_resp_stall"}, {31'b0, lsu_stall}, 32'd1);
          dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
          @(negedge clk);
          dmem_rvalid = 1'b0; dmem_rdata = '0;
          chk({p, "_wbv"},  {31'b0, wb_valid}, 32'd1);
          chk({p, "_wbwe"}, {31'b0, wb_we},    {31'b0, v.e_wbwe});
          chk({p, "_rd"},   {27'b0, wb_rd},    {27'b0, v.rd});
          chk({p, "_data"}, wb_data,           v.e_data);
        end
      end
    end else begin
      chk({p, "_wbv"},  {31'b0, wb_valid}, 32'd1);
      chk({p, "_wbwe"}, {31'b0, wb_we},    {31'b0, v.e_wbwe});
      chk({p, "_rd"},   {27'b0, wb_rd},    {27'b0, v.rd});
      chk({p, "_data"}, wb_data,           v.e_data);
      chk({p, "_mis"},  {31'b0, misalign}, 32'd0);
    end
    @(negedge clk);
    chk({p, "_pulse"}, {30'b0, wb_valid, misalign}, 32'd0);
  endtask

  initial begin
    //          op    f3      addr          sdata         rdata         rd  rwe mis e_addr        be       wdata         wbwe data
    vecs[0]  = '{2'd0, 3'b000, 32'h12345678, 32'h0,        32'h0,        5, 1, 0, 32'h0,        4'h0, 32'h0,        1, 32'h12345678};
    vecs[1]  = '{2'd3, 3'b010, 32'hDEADBEEF, 32'h0,        32'h0,        7, 0, 0, 32'h0,        4'h0, 32'h0,        0, 32'hDEADBEEF};
    vecs[2]  = '{2'd2, 3'b000, 32'h00000103, 32'h000000AB, 32'h0,        1, 0, 0, 32'h100,      4'h8, 32'hABABABAB, 0, 32'h0};
    vecs[3]  = '{2'd2, 3'b001, 32'h00000102, 32'h1234CDEF, 32'h0,        1, 0, 0, 32'h100,      4'hC, 32'hCDEFCDEF, 0, 32'h0};
    vecs[4]  = '{2'd2, 3'b010, 32'h00000204, 32'hCAFEF00D, 32'h0,        1, 0, 0, 32'h204,      4'hF, 32'hCAFEF00D, 0, 32'h0};
    vecs[5]  = '{2'd1, 3'b000, 32'h00000102, 32'h0,        32'h00800000, 2, 1, 0, 32'h100,      4'hF, 32'h0,        1, 32'hFFFFFF80};
    vecs[6]  = '{2'd1, 3'b100, 32'h00000102, 32'h0,        32'h00800000, 3, 1, 0, 32'h100,      4'hF, 32'h0,        1, 32'h00000080};
    vecs[7]  = '{2'd1, 3'b001, 32'h00000102, 32'h0,        32'h80011234, 4, 1, 0, 32'h100,      4'hF, 32'h0,        1, 32'hFFFF8001};
    vecs[8]  = '{2'd1, 3'b101, 32'h00000100, 32'h0,        32'h8001F234, 6, 1, 0, 32'h100,      4'hF, 32'h0,        1, 32'h0000F234};
    vecs[9]  = '{2'd1, 3'b010, 32'h00000108, 32'h0,        32'h89ABCDEF, 8, 1, 0, 32'h108,      4'hF, 32'h0,        1, 32'h89ABCDEF};
    vecs[10] = '{2'd1, 3'b001, 32'h00000101, 32'h0,        32'h0,        9, 1, 1, 32'h0,        4'h0, 32'h0,        0, 32'h0};
    vecs[11] = '{2'd1, 3'b010, 32'h00000106, 32'h0,        32'h0,        9, 1, 1, 32'h0,        4'h0, 32'h0,        0, 32'h0};
    vecs[12] = '{2'd2, 3'b010, 32'h00000102, 32'h0,        32'h0,        9, 0, 1, 32'h0,        4'h0, 32'h0,        0, 32'h0};
    vecs[13] = '{2'd1, 3'b011, 32'h0000010C, 32'h0,        32'h11223344, 10, 1, 0, 32'h10C,     4'hF, 32'h0,        1, 32'h11223344};
    vecs[14] = '{2'd1, 3'b000, 32'h00000101, 32'h0,        32'h00007F00, 11, 1, 0, 32'h100,     4'hF, 32'h0,        1, 32'h0000007F};
    vecs[15] = '{2'd1, 3'b010, 32'h00000200, 32'h0,        32'h5A5A0001, 12, 0, 0, 32'h200,     4'hF, 32'h0,        0, 32'h5A5A0001};

    rst = 1'b1; ex_valid = 1'b0; ex_result = '0; ex_store_data = '0; ex_mem_op = '0;
    ex_funct3 = '0; ex_rd = '0; ex_reg_we = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", {lsu_stall, dmem_req, dmem_we, wb_valid, wb_we, misalign, dmem_be}, 32'd0);
    chk("rst_bus",  dmem_addr | dmem_wdata, 32'd0);
    chk("rst_wb",   wb_data | {27'b0, wb_rd}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // SB with two wait states: request must stay stable for three cycles
    @(negedge clk);
    present(2'd2, 3'b000, 32'h103, 32'hAB, 5'd1, 1'b0);
    @(negedge clk);
    ex_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sbw_req%0d", k),   {31'b0, dmem_req},  32'd1);
      chk($sformatf("sbw_stall%0d", k), {31'b0, lsu_stall}, 32'd1);
      chk($sformatf("sbw_bus%0d", k),   dmem_wdata,         32'hABABABAB);
      chk($sformatf("sbw_ab%0d", k),    {dmem_addr[27:0], dmem_be}, {28'h0000100, 4'b1000});
      chk($sformatf("sbw_wbv%0d", k),   {31'b0, wb_valid},  32'd0);
      if (k == 2) dmem_gnt = 1'b1;
      @(negedge clk);
    end
    dmem_gnt = 1'b0;
    chk("sbw_wbv",   {31'b0, wb_valid}, 32'd1);
    chk("sbw_wbwe",  {31'b0, wb_we},    32'd0);
    chk("sbw_req",   {31'b0, dmem_req}, 32'd0);

    // LW followed by an ADD held by EX during the stall
    @(negedge clk);
    present(2'd1, 3'b010, 32'h110, 32'h0, 5'd3, 1'b1);
    @(negedge clk);
    present(2'd0, 3'b000, 32'h55, 32'h0, 5'd9, 1'b1);
    chk("b2b_stall", {31'b0, lsu_stall}, 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("b2b_nowb", {31'b0, wb_valid}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    chk("b2b_lw_wb", {wb_valid, 26'b0, wb_rd}, {1'b1, 26'b0, 5'd3});
    chk("b2b_lw_data", wb_data, 32'hA5A5A5A5);
    @(negedge clk);
    ex_valid = 1'b0;
    chk("b2b_add_wb", {wb_valid, wb_we, 25'b0, wb_rd}, {2'b11, 25'b0, 5'd9});
    chk("b2b_add_data", wb_data, 32'h55);
    @(negedge clk);
    chk("b2b_once", {31'b0, wb_valid}, 32'd0);

    // Reset asserted while waiting in RESP, then a stray rvalid/gnt
    present(2'd1, 3'b010, 32'h120, 32'h0, 5'd4, 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    chk("rr_inresp", {30'b0, lsu_stall, dmem_req}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rr_ctrl", {26'b0, lsu_stall, dmem_req, dmem_we, wb_valid, wb_we, misalign}, 32'd0);
    chk("rr_bus",  dmem_addr | dmem_wdata | {28'b0, dmem_be}, 32'd0);
    chk("rr_wb",   wb_data | {27'b0, wb_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_gnt = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
    chk("rr_stray", {30'b0, wb_valid, lsu_stall}, 32'd0);
    @(negedge clk);
    chk("rr_idle", {30'b0, wb_valid, dmem_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
